// File: rtl/aes_decipher_block.sv
// AES inverse cipher datapath for 128/192/256-bit keys.
// Decrypts one 128-bit block per start pulse using an iterative round
// structure. The inverse S-box lives outside this block and is shared one
// 32-bit word per cycle, so each round spends four cycles substituting
// words and one cycle on AddRoundKey, InvMixColumns and InvShiftRows.
// Round keys come from an external key memory addressed by `round`.

module aes_decipher_block (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic [1:0]   keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  inv_sboxw,
    input  logic [31:0]  new_inv_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    localparam logic [3:0] AES_128_ROUNDS = 4'ha;
    localparam logic [3:0] AES_192_ROUNDS = 4'hc;
    localparam logic [3:0] AES_256_ROUNDS = 4'he;

    localparam logic [1:0] KEYLEN_192 = 2'd1;
    localparam logic [1:0] KEYLEN_256 = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SBOX = 2'd2,
        MAIN = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1 (0x11b).
    // All larger constants are built from chained doublings.
    // ------------------------------------------------------------------
    function automatic logic [7:0] gm2(input logic [7:0] op);
        return {op[6:0], 1'b0} ^ (op[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm4(input logic [7:0] op);
        return gm2(gm2(op));
    endfunction

    function automatic logic [7:0] gm8(input logic [7:0] op);
        return gm2(gm4(op));
    endfunction

    function automatic logic [7:0] gm09(input logic [7:0] op);
        return gm8(op) ^ op;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] op);
        return gm8(op) ^ gm2(op) ^ op;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] op);
        return gm8(op) ^ gm4(op) ^ op;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] op);
        return gm8(op) ^ gm4(op) ^ gm2(op);
    endfunction

    // One column of InvMixColumns; byte 0 is the most significant byte.
    function automatic logic [31:0] inv_mixw(input logic [31:0] col);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] mb0, mb1, mb2, mb3;
        b0  = col[31:24];
        b1  = col[23:16];
        b2  = col[15:8];
        b3  = col[7:0];
        mb0 = gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm09(b3);
        mb1 = gm09(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3);
        mb2 = gm13(b0) ^ gm09(b1) ^ gm14(b2) ^ gm11(b3);
        mb3 = gm11(b0) ^ gm13(b1) ^ gm09(b2) ^ gm14(b3);
        return {mb0, mb1, mb2, mb3};
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] data);
        return {inv_mixw(data[127:96]), inv_mixw(data[95:64]),
                inv_mixw(data[63:32]),  inv_mixw(data[31:0])};
    endfunction

    // Row r moves right by r columns: new column c takes row r from
    // old column c-r (mod 4).
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] data);
        logic [31:0] c0, c1, c2, c3;
        logic [31:0] s0, s1, s2, s3;
        c0 = data[127:96];
        c1 = data[95:64];
        c2 = data[63:32];
        c3 = data[31:0];
        s0 = {c0[31:24], c3[23:16], c2[15:8], c1[7:0]};
        s1 = {c1[31:24], c0[23:16], c3[15:8], c2[7:0]};
        s2 = {c2[31:24], c1[23:16], c0[15:8], c3[7:0]};
        s3 = {c3[31:24], c2[23:16], c1[15:8], c0[7:0]};
        return {s0, s1, s2, s3};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state;
    logic [31:0] w0, w1, w2, w3;
    logic [1:0]  sword_ctr;
    logic [3:0]  round_ctr;

    logic [3:0]   num_rounds;
    logic [127:0] init_state;
    logic [127:0] keyed_state;
    logic [127:0] main_state;

    assign new_block = {w0, w1, w2, w3};
    assign round     = round_ctr;

    // Number of rounds for the selected key length; code 3 falls back to 128.
    always_comb begin
        num_rounds = AES_128_ROUNDS;
        if (keylen == KEYLEN_192) begin
            num_rounds = AES_192_ROUNDS;
        end else if (keylen == KEYLEN_256) begin
            num_rounds = AES_256_ROUNDS;
        end
    end

    // Word handed to the shared inverse S-box; quiet outside the SBOX phase.
    always_comb begin
        inv_sboxw = 32'h0;
        if (state == SBOX) begin
            case (sword_ctr)
                2'd0: inv_sboxw = w0;
                2'd1: inv_sboxw = w1;
                2'd2: inv_sboxw = w2;
                2'd3: inv_sboxw = w3;
            endcase
        end
    end

    // Round transforms: the initial whitening plus the per-round key mix,
    // InvMixColumns and the InvShiftRows belonging to the following round.
    always_comb begin
        init_state  = inv_shiftrows(block ^ round_key);
        keyed_state = new_block ^ round_key;
        main_state  = inv_shiftrows(inv_mixcolumns(keyed_state));
    end

    // Control FSM together with the state words and counters it sequences.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            w0        <= 32'h0;
            w1        <= 32'h0;
            w2        <= 32'h0;
            w3        <= 32'h0;
            sword_ctr <= 2'd0;
            round_ctr <= 4'd0;
            ready     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (next) begin
                        round_ctr <= num_rounds;
                        ready     <= 1'b0;
                        state     <= INIT;
                    end
                end

                INIT: begin
                    {w0, w1, w2, w3} <= init_state;
                    round_ctr        <= round_ctr - 4'd1;
                    sword_ctr        <= 2'd0;
                    state            <= SBOX;
                end

                SBOX: begin
                    case (sword_ctr)
                        2'd0: w0 <= new_inv_sboxw;
                        2'd1: w1 <= new_inv_sboxw;
                        2'd2: w2 <= new_inv_sboxw;
                        2'd3: w3 <= new_inv_sboxw;
                    endcase
                    sword_ctr <= sword_ctr + 2'd1;
                    if (sword_ctr == 2'd3) begin
                        state <= MAIN;
                    end
                end

                MAIN: begin
                    sword_ctr <= 2'd0;
                    if (round_ctr != 4'd0) begin
                        {w0, w1, w2, w3} <= main_state;
                        round_ctr        <= round_ctr - 4'd1;
                        state            <= SBOX;
                    end else begin
                        {w0, w1, w2, w3} <= keyed_state;
                        ready            <= 1'b1;
                        state            <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
